// File: rtl/dmem_fifo_ctl_8x16_pkg.sv
// Shared sizing and types for the 8x16 distributed-memory FIFO controller.
//   DMEM_DEPTH  words held in the storage array
//   DMEM_AW     storage address width
//   DMEM_DW     word width
//   DMEM_LVL_W  width of the level / high-water outputs (0..9)
//   PTR_W       pointer width: address plus one wrap bit
package dmem_fifo_ctl_8x16_pkg;

    localparam int DMEM_DEPTH = 8;
    localparam int DMEM_AW    = 3;
    localparam int DMEM_DW    = 16;
    localparam int DMEM_LVL_W = 4;
    localparam int PTR_W      = DMEM_AW + 1;

    typedef logic [DMEM_DW-1:0]    word_t;
    typedef logic [PTR_W-1:0]      ptr_t;
    typedef logic [DMEM_LVL_W-1:0] lvl_t;

    // Ring occupancy; the wrap bit makes 8 distinguishable from 0.
    function automatic lvl_t ring_cnt(input ptr_t wr, input ptr_t rd);
        return lvl_t'(wr - rd);
    endfunction

endpackage

// File: rtl/dmem_fifo_ctl_8x16_if.sv
// Producer/consumer bundle for dmem_fifo_ctl_8x16.
//   slave  : the FIFO controller (takes i_*, drives o_*)
//   master : the environment (producer, consumer and stats observer)
interface dmem_fifo_ctl_8x16_if;
    import dmem_fifo_ctl_8x16_pkg::*;

    word_t       i_wr_data;
    logic        i_wr_valid;
    logic        o_wr_ready;
    word_t       o_rd_data;
    logic        o_rd_valid;
    logic        i_rd_ready;
    lvl_t        o_level;
    logic        o_almost_full;
    logic        i_stats_clr;
    lvl_t        o_hwm;
    logic [15:0] o_stall_cnt;

    modport slave (
        input  i_wr_data, i_wr_valid, i_rd_ready, i_stats_clr,
        output o_wr_ready, o_rd_data, o_rd_valid, o_level, o_almost_full,
               o_hwm, o_stall_cnt
    );

    modport master (
        output i_wr_data, i_wr_valid, i_rd_ready, i_stats_clr,
        input  o_wr_ready, o_rd_data, o_rd_valid, o_level, o_almost_full,
               o_hwm, o_stall_cnt
    );

endinterface

// File: rtl/dmem_fifo_ctl_8x16_mem.sv
// xil_dmem_tp_8x16: 8x16 two-port distributed RAM, synchronous write,
// asynchronous read. No reset: contents are undefined until written.
//   clk_wr     write clock
//   i_wr_en    write strobe
//   i_wr_adr   write address
//   i_wr_data  write word
//   i_rd_adr   read address
//   o_rd_data  combinational read word
module xil_dmem_tp_8x16
    import dmem_fifo_ctl_8x16_pkg::*;
(
    input  logic               clk_wr,
    input  logic               i_wr_en,
    input  logic [DMEM_AW-1:0] i_wr_adr,
    input  word_t              i_wr_data,
    input  logic [DMEM_AW-1:0] i_rd_adr,
    output word_t              o_rd_data
);

    word_t mem [DMEM_DEPTH];

    always_ff @(posedge clk_wr) begin
        if (i_wr_en) mem[i_wr_adr] <= i_wr_data;
    end

    assign o_rd_data = mem[i_rd_adr];

endmodule

// File: rtl/dmem_fifo_ctl_8x16.sv
// dmem_fifo_ctl_8x16: single-clock ring-buffer FIFO around one 8x16 distributed
// RAM with a registered output stage (holds a 9th word, hides the async read).
//   clk, rst_n   clock, asynchronous active-low reset
//   bus (slave)  write valid/ready, read valid/ready, level, almost-full, stats
// Parameter AFULL_THR: o_almost_full when o_level >= AFULL_THR (1..9).
// Optional macro DMEM_FIFO_STATS_EN adds the high-water mark and producer-stall
// counter; without it those outputs are tied to zero and i_stats_clr is unused.
module dmem_fifo_ctl_8x16
    import dmem_fifo_ctl_8x16_pkg::*;
#(
    parameter int AFULL_THR = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dmem_fifo_ctl_8x16_if.slave    bus
);

    localparam lvl_t AFULL_L = lvl_t'(AFULL_THR);

    ptr_t  wr_ptr, rd_ptr;
    logic  wr_ready_q, rd_valid_q, afull_q;
    word_t rd_data_q, mem_rd;
    lvl_t  level_q;

    logic  push, pop, load, rd_valid_nxt;
    ptr_t  wr_ptr_nxt, rd_ptr_nxt;
    lvl_t  mem_cnt, mem_cnt_nxt, level_nxt;

    assign push    = bus.i_wr_valid & wr_ready_q;
    assign pop     = rd_valid_q & bus.i_rd_ready;
    assign mem_cnt = ring_cnt(wr_ptr, rd_ptr);
    // Load only from words present at the start of the cycle, so a word is
    // never read from the address being written in the same cycle.
    assign load    = (mem_cnt != '0) & (~rd_valid_q | pop);

    assign wr_ptr_nxt   = wr_ptr + ptr_t'(push);
    assign rd_ptr_nxt   = rd_ptr + ptr_t'(load);
    assign mem_cnt_nxt  = ring_cnt(wr_ptr_nxt, rd_ptr_nxt);
    assign rd_valid_nxt = load | (rd_valid_q & ~pop);
    assign level_nxt    = mem_cnt_nxt + lvl_t'(rd_valid_nxt);

    xil_dmem_tp_8x16 u_mem (
        .clk_wr    (clk),
        .i_wr_en   (push),
        .i_wr_adr  (wr_ptr[DMEM_AW-1:0]),
        .i_wr_data (bus.i_wr_data),
        .i_rd_adr  (rd_ptr[DMEM_AW-1:0]),
        .o_rd_data (mem_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wr_ready_q <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            level_q    <= '0;
            afull_q    <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            wr_ready_q <= (mem_cnt_nxt != lvl_t'(DMEM_DEPTH));
            rd_valid_q <= rd_valid_nxt;
            if (load) rd_data_q <= mem_rd;
            level_q    <= level_nxt;
            afull_q    <= (level_nxt >= AFULL_L);
        end
    end

    assign bus.o_wr_ready    = wr_ready_q;
    assign bus.o_rd_valid    = rd_valid_q;
    assign bus.o_rd_data     = rd_data_q;
    assign bus.o_level       = level_q;
    assign bus.o_almost_full = afull_q;

`ifdef DMEM_FIFO_STATS_EN
    lvl_t        hwm_q;
    logic [15:0] stall_q;

    // Clear has priority over the same-cycle update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwm_q   <= '0;
            stall_q <= '0;
        end else if (bus.i_stats_clr) begin
            hwm_q   <= '0;
            stall_q <= '0;
        end else begin
            if (level_q > hwm_q) hwm_q <= level_q;
            if (bus.i_wr_valid & ~wr_ready_q & (stall_q != 16'hFFFF))
                stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.o_hwm       = hwm_q;
    assign bus.o_stall_cnt = stall_q;
`else
    assign bus.o_hwm       = '0;
    assign bus.o_stall_cnt = '0;
`endif

endmodule
